// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage (fetch_unit and return_stack).
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BRANCH = 3'd1,
        RD_REL    = 3'd2,
        RD_CALL   = 3'd3,
        RD_RET    = 3'd4
    } redirect_kind_t;

    localparam int SEXT_W = 64;

    // Sign-extends the low off_w bits of off to SEXT_W bits; callers truncate to PC width.
    function automatic logic [SEXT_W-1:0] sext_off(input logic [SEXT_W-1:0] off, input int off_w);
        logic signed [SEXT_W-1:0] w_tmp;
        w_tmp = $signed(off << (SEXT_W - off_w));
        return w_tmp >>> (SEXT_W - off_w);
    endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry, a pop when empty
// leaves the pointer at empty. o_err flags either case in the cycle it happens.
module return_stack
    import fetch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_push_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_full,
    output logic            o_empty,
    output logic            o_err
);

    localparam int IDX_W = $clog2(RAS_DEPTH);
    localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(RAS_DEPTH);

    logic [PC_W-1:0]  r_mem [RAS_DEPTH];
    logic [IDX_W-1:0] r_top_idx;
    logic [IDX_W:0]   r_count;
    logic [IDX_W-1:0] w_push_idx;

    assign w_push_idx = r_top_idx + IDX_W'(1);
    assign o_full     = (r_count == DEPTH_CNT);
    assign o_empty    = (r_count == '0);
    assign o_top      = r_mem[r_top_idx];
    assign o_err      = (i_push && o_full) || (i_pop && o_empty);

    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_top_idx <= '0;
            r_count   <= '0;
        end else if (i_clear) begin
            r_top_idx <= '0;
            r_count   <= '0;
        end else if (i_push) begin
            r_top_idx <= w_push_idx;
            if (!o_full) r_count <= r_count + (IDX_W+1)'(1);
        end else if (i_pop && !o_empty) begin
            r_top_idx <= r_top_idx - IDX_W'(1);
            r_count   <= r_count - (IDX_W+1)'(1);
        end
    end

    // NOTE: storage has no reset; entries are only read after being pushed, and the pointer reset makes the stack empty.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) r_mem[w_push_idx] <= i_push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IDLE/RUN/HALTED control, valid/ready output and redirects.
// Define FETCH_RAS_EN to build the return-address stack for Call/Return.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W      = 16,
    parameter int INSTR_W   = 9,
    parameter int OFF_W     = 8,
    parameter int RAS_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [PC_W-1:0]    i_start_address,
    input  logic               i_halt,
    input  logic               i_branch,
    input  logic               i_branch_rel,
    input  logic               i_call,
    input  logic               i_return,
    input  logic [PC_W-1:0]    i_branch_target,
    input  logic [OFF_W-1:0]   i_offset,
    input  logic [PC_W-1:0]    i_redirect_pc,
    output logic [PC_W-1:0]    o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_data,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_instr_pc,
    output logic               o_instr_valid,
    input  logic               i_instr_ready,
    output logic               o_halted,
    output logic               o_ras_err
);

    fetch_state_t   r_state, w_state_next;
    redirect_kind_t w_rd_kind;

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_instr_pc;
    logic               r_instr_valid;
    logic               r_ras_err;

    logic               w_redirect;
    logic               w_fire;
    logic               w_ras_err;
    logic [PC_W-1:0]    w_off_ext;
    logic [PC_W-1:0]    w_rel_target;
    logic [PC_W-1:0]    w_ras_target;
    logic [PC_W-1:0]    w_target;

    assign w_off_ext    = PC_W'(sext_off(SEXT_W'(i_offset), OFF_W));
    assign w_rel_target = i_redirect_pc + w_off_ext;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_rd_kind = RD_NONE;
        if (i_return)          w_rd_kind = RD_RET;
        else if (i_call)       w_rd_kind = RD_CALL;
        else if (i_branch_rel) w_rd_kind = RD_REL;
        else if (i_branch)     w_rd_kind = RD_BRANCH;
    end

    assign w_redirect = (r_state == RUN) && !i_start && !i_halt && (w_rd_kind != RD_NONE);
    assign w_fire     = (r_state == RUN) && !i_start && !i_halt && !w_redirect
                        && (!r_instr_valid || i_instr_ready);

    always_comb begin
        w_target = i_branch_target;
        case (w_rd_kind)
            RD_REL:  w_target = w_rel_target;
            RD_RET:  w_target = w_ras_target;
            default: w_target = i_branch_target;
        endcase
    end

`ifdef FETCH_RAS_EN
    logic            w_ras_push;
    logic            w_ras_pop;
    logic            w_ras_empty;
    logic            w_ras_full_unused;
    logic [PC_W-1:0] w_ras_top;

    assign w_ras_push = w_redirect && (w_rd_kind == RD_CALL);
    assign w_ras_pop  = w_redirect && (w_rd_kind == RD_RET);

    return_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clear     (i_start),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_data (i_redirect_pc + PC_W'(1)),
        .o_top       (w_ras_top),
        .o_full      (w_ras_full_unused),
        .o_empty     (w_ras_empty),
        .o_err       (w_ras_err)
    );

    assign w_ras_target = w_ras_empty ? '0 : w_ras_top;
`else
    assign w_ras_target = i_branch_target;
    assign w_ras_err    = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (i_start)     w_state_next = RUN;
        else if (i_halt) w_state_next = HALTED;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc          <= '0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_ras_err     <= 1'b0;
        end else begin
            if (w_ras_err) r_ras_err <= 1'b1;
            if (i_start) begin
                r_pc          <= i_start_address;
                r_instr_valid <= 1'b0;
            end else if (i_halt) begin
                r_instr_valid <= 1'b0;
            end else if (w_redirect) begin
                r_pc          <= w_target;
                r_instr_valid <= 1'b0;
            end else if (w_fire) begin
                r_instr       <= i_imem_data;
                r_instr_pc    <= r_pc;
                r_instr_valid <= 1'b1;
                r_pc          <= r_pc + PC_W'(1);
            end
        end
    end

    assign o_imem_addr   = r_pc;
    assign o_instr       = r_instr;
    assign o_instr_pc    = r_instr_pc;
    assign o_instr_valid = r_instr_valid;
    assign o_halted      = (r_state == HALTED);
    assign o_ras_err     = r_ras_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed and random stimulus against a queue-based
// reference model; a negedge monitor compares per-cycle status and every accepted instruction.
module tb_fetch_unit;

    localparam int PC_W      = 16;
    localparam int INSTR_W   = 9;
    localparam int OFF_W     = 8;
    localparam int RAS_DEPTH = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_start;
    logic [PC_W-1:0]    i_start_address;
    logic               i_halt;
    logic               i_branch;
    logic               i_branch_rel;
    logic               i_call;
    logic               i_return;
    logic [PC_W-1:0]    i_branch_target;
    logic [OFF_W-1:0]   i_offset;
    logic [PC_W-1:0]    i_redirect_pc;
    logic [PC_W-1:0]    o_imem_addr;
    logic [INSTR_W-1:0] i_imem_data;
    logic [INSTR_W-1:0] o_instr;
    logic [PC_W-1:0]    o_instr_pc;
    logic               o_instr_valid;
    logic               i_instr_ready;
    logic               o_halted;
    logic               o_ras_err;

    fetch_unit #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .OFF_W     (OFF_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_start         (i_start),
        .i_start_address (i_start_address),
        .i_halt          (i_halt),
        .i_branch        (i_branch),
        .i_branch_rel    (i_branch_rel),
        .i_call          (i_call),
        .i_return        (i_return),
        .i_branch_target (i_branch_target),
        .i_offset        (i_offset),
        .i_redirect_pc   (i_redirect_pc),
        .o_imem_addr     (o_imem_addr),
        .i_imem_data     (i_imem_data),
        .o_instr         (o_instr),
        .o_instr_pc      (o_instr_pc),
        .o_instr_valid   (o_instr_valid),
        .i_instr_ready   (i_instr_ready),
        .o_halted        (o_halted),
        .o_ras_err       (o_ras_err)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [INSTR_W-1:0] imem_word(input logic [PC_W-1:0] a);
        return INSTR_W'((a * 16'd37) ^ (a >> 5) ^ 16'h00A5);
    endfunction

    assign i_imem_data = imem_word(o_imem_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a fetch slot, a PC and a return stack kept as a plain queue.
    typedef enum {M_IDLE, M_RUN, M_HALT} mstate_t;
    typedef struct { logic [PC_W-1:0] addr; logic valid; logic halted; logic ras_err; } status_t;
    typedef struct { logic [PC_W-1:0] pc; logic [INSTR_W-1:0] instr; } xfer_t;

    mstate_t         m_state;
    logic [PC_W-1:0] m_pc;
    logic            m_valid;
    logic [PC_W-1:0] m_ipc;
    logic [INSTR_W-1:0] m_instr;
    logic            m_err;
    logic [PC_W-1:0] m_ras[$];

    status_t status_q[$];
    xfer_t   xfer_q[$];
    bit      running = 1'b0;

    logic [PC_W-1:0] ret_exp [5] = '{16'h0015, 16'h0014, 16'h0013, 16'h0012, 16'h0000};

    task automatic model_reset();
        m_state = M_IDLE;
        m_pc    = '0;
        m_valid = 1'b0;
        m_ipc   = '0;
        m_instr = '0;
        m_err   = 1'b0;
        m_ras.delete();
    endtask

    task automatic model_redirect();
        logic [PC_W-1:0] t;
        if (i_return) begin
`ifdef FETCH_RAS_EN
            if (m_ras.size() == 0) begin
                t = '0;
                m_err = 1'b1;
            end else begin
                t = m_ras.pop_back();
            end
`else
            t = i_branch_target;
`endif
        end else if (i_call) begin
`ifdef FETCH_RAS_EN
            m_ras.push_back(i_redirect_pc + 16'd1);
            if (m_ras.size() > RAS_DEPTH) begin
                void'(m_ras.pop_front());
                m_err = 1'b1;
            end
`endif
            t = i_branch_target;
        end else if (i_branch_rel) begin
            t = 16'(int'(i_redirect_pc) + int'($signed(i_offset)));
        end else begin
            t = i_branch_target;
        end
        m_pc    = t;
        m_valid = 1'b0;
    endtask

    task automatic model_advance();
        if (i_start) begin
            m_state = M_RUN;
            m_pc    = i_start_address;
            m_valid = 1'b0;
            m_ras.delete();
        end else if (i_halt) begin
            if (m_state != M_HALT) begin
                m_state = M_HALT;
                m_valid = 1'b0;
            end
        end else if (m_state == M_RUN) begin
            if (i_return || i_call || i_branch_rel || i_branch) begin
                model_redirect();
            end else if (!m_valid || i_instr_ready) begin
                m_ipc   = m_pc;
                m_instr = imem_word(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd1;
            end
        end
    endtask

    // Called at posedge+1 with this cycle's inputs applied; queues what the monitor must see, then advances one edge.
    task automatic step();
        status_t s;
        xfer_t   x;
        if (i_rst) model_reset();
        s.addr    = m_pc;
        s.valid   = m_valid;
        s.halted  = (m_state == M_HALT);
        s.ras_err = m_err;
        status_q.push_back(s);
        if (!i_rst && m_valid && i_instr_ready) begin
            x.pc    = m_ipc;
            x.instr = m_instr;
            xfer_q.push_back(x);
        end
        if (!i_rst) model_advance();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_strobes();
        i_start      = 1'b0;
        i_halt       = 1'b0;
        i_branch     = 1'b0;
        i_branch_rel = 1'b0;
        i_call       = 1'b0;
        i_return     = 1'b0;
    endtask

    always @(negedge i_clk) begin : monitor
        status_t s;
        xfer_t   x;
        if (running) begin
            if (status_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL status_queue: no expectation queued (t=%0t)", $time);
            end else begin
                s = status_q.pop_front();
                check("imem_addr", 32'(o_imem_addr), 32'(s.addr));
                check("instr_valid", 32'(o_instr_valid), 32'(s.valid));
                check("halted", 32'(o_halted), 32'(s.halted));
                check("ras_err", 32'(o_ras_err), 32'(s.ras_err));
            end
            if (o_instr_valid && i_instr_ready) begin
                if (xfer_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL xfer_queue: DUT delivered pc 0x%0h with nothing expected (t=%0t)", o_instr_pc, $time);
                end else begin
                    x = xfer_q.pop_front();
                    check("xfer_pc", 32'(o_instr_pc), 32'(x.pc));
                    check("xfer_instr", 32'(o_instr), 32'(x.instr));
                end
            end
        end
    end

    initial begin
        clear_strobes();
        i_rst           = 1'b1;
        i_instr_ready   = 1'b1;
        i_start_address = '0;
        i_branch_target = '0;
        i_offset        = '0;
        i_redirect_pc   = '0;
        model_reset();
        @(posedge i_clk);
        #1;
        running = 1'b1;
        step();
        i_rst = 1'b0;
        step();
        check("idle_addr", 32'(o_imem_addr), 32'h0);
        check("idle_valid", 32'(o_instr_valid), 32'h0);

        // Asynchronous reset in the middle of RUN.
        i_start = 1'b1; i_start_address = 16'h0003; step(); i_start = 1'b0;
        step(); step();
        check("pre_reset_addr", 32'(o_imem_addr), 32'h5);
        i_rst = 1'b1;
        #1;
        check("async_rst_addr", 32'(o_imem_addr), 32'h0);
        check("async_rst_valid", 32'(o_instr_valid), 32'h0);
        check("async_rst_instr", 32'(o_instr), 32'h0);
        check("async_rst_ipc", 32'(o_instr_pc), 32'h0);
        check("async_rst_halted", 32'(o_halted), 32'h0);
        check("async_rst_ras_err", 32'(o_ras_err), 32'h0);
        step();
        i_rst = 1'b0;
        step(); step();
        check("idle_hold_addr", 32'(o_imem_addr), 32'h0);

        // Start, stream, stall, resume.
        i_start = 1'b1; i_start_address = 16'h0010; step(); i_start = 1'b0;
        check("start_valid_low", 32'(o_instr_valid), 32'h0);
        check("start_addr", 32'(o_imem_addr), 32'h10);
        step(); check("first_ipc", 32'(o_instr_pc), 32'h10);
        check("first_valid", 32'(o_instr_valid), 32'h1);
        step(); check("second_ipc", 32'(o_instr_pc), 32'h11);
        step(); check("third_ipc", 32'(o_instr_pc), 32'h12);
        i_instr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("stall_ipc", 32'(o_instr_pc), 32'h12);
            check("stall_addr", 32'(o_imem_addr), 32'h13);
            check("stall_instr", 32'(o_instr), 32'(imem_word(16'h0012)));
        end
        i_instr_ready = 1'b1;
        step(); check("resume_ipc", 32'(o_instr_pc), 32'h13);

        // Relative branch backwards across zero.
        i_branch_rel = 1'b1; i_redirect_pc = 16'h0002; i_offset = 8'hFC; step(); i_branch_rel = 1'b0;
        check("rel_bubble", 32'(o_instr_valid), 32'h0);
        check("rel_target", 32'(o_imem_addr), 32'hFFFE);
        step(); check("rel_ipc0", 32'(o_instr_pc), 32'hFFFE);
        step(); check("rel_ipc1", 32'(o_instr_pc), 32'hFFFF);
        step(); check("rel_ipc_wrap", 32'(o_instr_pc), 32'h0000);

`ifdef FETCH_RAS_EN
        i_start = 1'b1; i_start_address = 16'h0100; step(); i_start = 1'b0;
        step();
        i_branch_target = 16'h0200;
        for (int k = 0; k < 5; k++) begin
            i_call = 1'b1; i_redirect_pc = 16'(16'h0010 + k); step();
        end
        i_call = 1'b0;
        check("ras_overflow", 32'(o_ras_err), 32'h1);
        for (int k = 0; k < 5; k++) begin
            i_return = 1'b1; step();
            check("ras_return", 32'(o_imem_addr), 32'(ret_exp[k]));
        end
        i_return = 1'b0;
        step();
`endif

        // Halt beats simultaneous redirects; frozen until Start.
        i_start = 1'b1; i_start_address = 16'h0040; step(); i_start = 1'b0;
        step();
        i_halt = 1'b1; i_branch = 1'b1; i_call = 1'b1;
        i_redirect_pc = 16'h0050; i_branch_target = 16'h0060;
        step();
        i_halt = 1'b0;
        check("halt_flag", 32'(o_halted), 32'h1);
        check("halt_addr", 32'(o_imem_addr), 32'h41);
        check("halt_valid", 32'(o_instr_valid), 32'h0);
        for (int k = 0; k < 4; k++) begin
            i_instr_ready = 1'($urandom_range(0, 1));
            i_return = 1'b1;
            step();
            check("halt_frozen_addr", 32'(o_imem_addr), 32'h41);
        end
        clear_strobes();
        i_instr_ready = 1'b1;
        i_start = 1'b1; i_start_address = 16'h0070; step(); i_start = 1'b0;
        check("restart_halted", 32'(o_halted), 32'h0);
        check("restart_addr", 32'(o_imem_addr), 32'h70);

        // Random traffic checked entirely by the scoreboard.
        for (int c = 0; c < 3000; c++) begin
            i_rst           = ($urandom_range(0, 399) == 0);
            i_start         = ($urandom_range(0, 49) == 0);
            i_halt          = ($urandom_range(0, 59) == 0);
            i_branch        = ($urandom_range(0, 7) == 0);
            i_branch_rel    = ($urandom_range(0, 7) == 0);
            i_call          = ($urandom_range(0, 7) == 0);
            i_return        = ($urandom_range(0, 7) == 0);
            i_instr_ready   = ($urandom_range(0, 3) != 0);
            i_start_address = 16'($urandom);
            i_branch_target = 16'($urandom);
            i_offset        = 8'($urandom);
            i_redirect_pc   = 16'($urandom);
            step();
        end

        i_rst = 1'b0;
        clear_strobes();
        step();
        step();
        running = 1'b0;
        check("status_q_drained", 32'(status_q.size()), 32'h0);
        check("xfer_q_drained", 32'(xfer_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
